// File: rtl/obi_apb_splitter_pkg.sv
`default_nettype none
// ============================================================================
// obi_apb_splitter_pkg : FSM state encoding and width helpers for the splitter.
// Rev 1.0
// ============================================================================
package obi_apb_splitter_pkg;

   typedef logic [1:0] state_t;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // IDX_W = $clog2(NUM_TARGETS), kept at least 1 bit wide for a single target.
   function automatic int idx_width(input int num_targets);
      return (num_targets > 1) ? $clog2(num_targets) : 1;
   endfunction

   // CNT_W = $clog2(TIMEOUT_CYCLES+1), kept at least 1 bit when the timeout is off.
   function automatic int cnt_width(input int timeout_cycles);
      return (timeout_cycles > 0) ? $clog2(timeout_cycles + 1) : 1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/obi_apb_addr_decode.sv
`default_nettype none
// ============================================================================
// obi_apb_addr_decode : maps an address onto ascending SS_SIZE target windows.
// Rev 1.0
// ============================================================================
module obi_apb_addr_decode #(
   parameter int              AW          = 32,
   parameter int              IDX_W       = 3,
   parameter logic [AW-1:0]   ADDR_BASE   = '0,
   parameter int unsigned     SS_SIZE     = 32'h1000,
   parameter int              NUM_TARGETS = 5
) (
   input  logic [AW-1:0]    addr_i,
   output logic [IDX_W-1:0] idx_o,
   output logic             hit_o
);

   localparam int          C_SHIFT = $clog2(SS_SIZE);
   localparam logic [63:0] C_LO    = 64'(ADDR_BASE);
   localparam logic [63:0] C_HI    = C_LO + 64'(NUM_TARGETS) * 64'(SS_SIZE);

   // 64-bit arithmetic so the window end never wraps at the top of the map.
   logic [63:0] w_addr;

   assign w_addr = 64'(addr_i);
   assign hit_o  = (w_addr >= C_LO) && (w_addr < C_HI);
   assign idx_o  = IDX_W'((w_addr - C_LO) >> C_SHIFT);

endmodule
`default_nettype wire

// File: rtl/obi_apb_splitter.sv
`default_nettype none
// ============================================================================
// obi_apb_splitter : single-initiator OBI to NUM_TARGETS-way APB splitter with
//                    per-target enable, unmapped-address error and PREADY timeout.
// Rev 1.0
// ============================================================================
module obi_apb_splitter
   import obi_apb_splitter_pkg::*;
#(
   parameter int                OBI_AW         = 32,
   parameter int                OBI_DW         = 32,
   parameter int                OBI_IDW        = 1,
   parameter int                APB_AW         = 32,
   parameter int                APB_DW         = 32,
   parameter int                NUM_TARGETS    = 5,
   parameter logic [OBI_AW-1:0] ADDR_BASE      = 32'h0105_0000,
   parameter int unsigned       SS_SIZE        = 32'h1000,
   parameter int                TIMEOUT_CYCLES = 256,
   parameter int                SS_CTRL_W      = 7
) (
   input  logic                            clk,
   input  logic                            reset_n,
   input  logic                            obi_req,
   output logic                            obi_gnt,
   output logic                            obi_gntpar,
   input  logic [OBI_AW-1:0]               obi_addr,
   input  logic                            obi_we,
   input  logic [OBI_DW/8-1:0]             obi_be,
   input  logic [OBI_DW-1:0]               obi_wdata,
   input  logic [OBI_IDW-1:0]              obi_aid,
   input  logic                            obi_reqpar,
   input  logic                            obi_rready,
   input  logic                            obi_rreadypar,
   output logic                            obi_rvalid,
   output logic                            obi_rvalidpar,
   output logic [OBI_DW-1:0]               obi_rdata,
   output logic [OBI_IDW-1:0]              obi_rid,
   output logic                            obi_err,
   input  logic [SS_CTRL_W-1:0]            ss_ctrl_icn,
   output logic [NUM_TARGETS*APB_AW-1:0]   apb_paddr,
   output logic [NUM_TARGETS-1:0]          apb_psel,
   output logic [NUM_TARGETS-1:0]          apb_penable,
   output logic [NUM_TARGETS-1:0]          apb_pwrite,
   output logic [NUM_TARGETS*APB_DW-1:0]   apb_pwdata,
   output logic [NUM_TARGETS*APB_DW/8-1:0] apb_pstrb,
   input  logic [NUM_TARGETS*APB_DW-1:0]   apb_prdata,
   input  logic [NUM_TARGETS-1:0]          apb_pready,
   input  logic [NUM_TARGETS-1:0]          apb_pslverr
);

   localparam int IDX_W = idx_width(NUM_TARGETS);
   localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] C_TO_LAST =
      CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

   state_t                state_q, state_d;
   logic [APB_AW-1:0]     addr_q, addr_d;
   logic                  we_q, we_d;
   logic [APB_DW/8-1:0]   strb_q, strb_d;
   logic [APB_DW-1:0]     wdata_q, wdata_d;
   logic [IDX_W-1:0]      idx_q, idx_d;
   logic [OBI_IDW-1:0]    rid_q, rid_d;
   logic [OBI_DW-1:0]     rdata_q, rdata_d;
   logic                  err_q, err_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;

   logic [IDX_W-1:0]      w_idx;
   logic                  w_hit;
   logic                  w_en;
   logic                  w_valid;
   logic [APB_DW-1:0]     w_prdata;
   logic                  w_pready;
   logic                  w_pslverr;
   logic                  w_timeout;
   logic                  w_active;
   logic                  w_unused;

   obi_apb_addr_decode #(
      .AW          (OBI_AW),
      .IDX_W       (IDX_W),
      .ADDR_BASE   (ADDR_BASE),
      .SS_SIZE     (SS_SIZE),
      .NUM_TARGETS (NUM_TARGETS)
   ) u_decode (
      .addr_i (obi_addr),
      .idx_o  (w_idx),
      .hit_o  (w_hit)
   );

   // Enable lookup is bounded to real targets; reserved control bits never decode.
   always_comb begin
      w_en = 1'b0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (w_idx == IDX_W'(i)) begin
            w_en = ss_ctrl_icn[i];
         end
      end
   end

   assign w_valid = w_hit && w_en;

   always_comb begin
      w_prdata  = '0;
      w_pready  = 1'b0;
      w_pslverr = 1'b0;
      for (int i = 0; i < NUM_TARGETS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            w_prdata  = apb_prdata[i*APB_DW +: APB_DW];
            w_pready  = apb_pready[i];
            w_pslverr = apb_pslverr[i];
         end
      end
   end

   assign w_timeout = (TIMEOUT_CYCLES != 0) && (cnt_q == C_TO_LAST);

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      we_d    = we_q;
      strb_d  = strb_q;
      wdata_d = wdata_q;
      idx_d   = idx_q;
      rid_d   = rid_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (obi_req) begin
               rid_d = obi_aid;
               if (w_valid) begin
                  addr_d  = obi_addr[APB_AW-1:0];
                  we_d    = obi_we;
                  strb_d  = obi_we ? obi_be : '0;
                  wdata_d = obi_wdata;
                  idx_d   = w_idx;
                  state_d = ST_SETUP;
               end else begin
                  rdata_d = '0;
                  err_d   = 1'b1;
                  state_d = ST_RESP;
               end
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + CNT_W'(1);
            // A completing target takes priority over a timeout in the same cycle.
            if (w_pready) begin
               rdata_d = we_q ? '0 : w_prdata;
               err_d   = w_pslverr;
               state_d = ST_RESP;
            end else if (w_timeout) begin
               rdata_d = '0;
               err_d   = 1'b1;
               state_d = ST_RESP;
            end
         end
         ST_RESP: begin
            if (obi_rready) begin
               cnt_d   = '0;
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         strb_q  <= '0;
         wdata_q <= '0;
         idx_q   <= '0;
         rid_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         strb_q  <= strb_d;
         wdata_q <= wdata_d;
         idx_q   <= idx_d;
         rid_q   <= rid_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign obi_gnt       = (state_q == ST_IDLE) && obi_req;
   assign obi_gntpar    = ~obi_gnt;
   assign obi_rvalid    = (state_q == ST_RESP);
   assign obi_rvalidpar = ~obi_rvalid;
   assign obi_rdata     = rdata_q;
   assign obi_rid       = rid_q;
   assign obi_err       = err_q;

   assign w_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);

   // Address/data buses are broadcast; only PSEL/PENABLE are per target.
   for (genvar i = 0; i < NUM_TARGETS; i++) begin : g_tgt
      assign apb_psel[i]                            = w_active && (idx_q == IDX_W'(i));
      assign apb_penable[i]                         = (state_q == ST_ACCESS) && (idx_q == IDX_W'(i));
      assign apb_pwrite[i]                          = we_q;
      assign apb_paddr[i*APB_AW +: APB_AW]          = addr_q;
      assign apb_pwdata[i*APB_DW +: APB_DW]         = wdata_q;
      assign apb_pstrb[i*(APB_DW/8) +: (APB_DW/8)]  = strb_q;
   end

   assign w_unused = ^{obi_reqpar, obi_rreadypar, ss_ctrl_icn};

endmodule
`default_nettype wire

// File: tb/tb_obi_apb_splitter.sv
`default_nettype none
// ============================================================================
// tb_obi_apb_splitter : directed scoreboard bench for obi_apb_splitter.
// Rev 1.0
// ============================================================================
module tb_obi_apb_splitter;

   localparam int NT = 5;
   localparam int DW = 32;

   logic              clk;
   logic              reset_n;
   logic              obi_req, obi_gnt, obi_gntpar;
   logic [31:0]       obi_addr;
   logic              obi_we;
   logic [3:0]        obi_be;
   logic [31:0]       obi_wdata;
   logic [0:0]        obi_aid;
   logic              obi_reqpar, obi_rready, obi_rreadypar;
   logic              obi_rvalid, obi_rvalidpar;
   logic [31:0]       obi_rdata;
   logic [0:0]        obi_rid;
   logic              obi_err;
   logic [6:0]        ss_ctrl_icn;
   logic [NT*32-1:0]  apb_paddr;
   logic [NT-1:0]     apb_psel, apb_penable, apb_pwrite;
   logic [NT*DW-1:0]  apb_pwdata;
   logic [NT*4-1:0]   apb_pstrb;
   logic [NT*DW-1:0]  apb_prdata;
   logic [NT-1:0]     apb_pready, apb_pslverr;

   obi_apb_splitter #(
      .NUM_TARGETS    (NT),
      .TIMEOUT_CYCLES (8)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .obi_req       (obi_req),
      .obi_gnt       (obi_gnt),
      .obi_gntpar    (obi_gntpar),
      .obi_addr      (obi_addr),
      .obi_we        (obi_we),
      .obi_be        (obi_be),
      .obi_wdata     (obi_wdata),
      .obi_aid       (obi_aid),
      .obi_reqpar    (obi_reqpar),
      .obi_rready    (obi_rready),
      .obi_rreadypar (obi_rreadypar),
      .obi_rvalid    (obi_rvalid),
      .obi_rvalidpar (obi_rvalidpar),
      .obi_rdata     (obi_rdata),
      .obi_rid       (obi_rid),
      .obi_err       (obi_err),
      .ss_ctrl_icn   (ss_ctrl_icn),
      .apb_paddr     (apb_paddr),
      .apb_psel      (apb_psel),
      .apb_penable   (apb_penable),
      .apb_pwrite    (apb_pwrite),
      .apb_pwdata    (apb_pwdata),
      .apb_pstrb     (apb_pstrb),
      .apb_prdata    (apb_prdata),
      .apb_pready    (apb_pready),
      .apb_pslverr   (apb_pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // APB target model: PREADY after wcfg[i] wait states in ACCESS.
   int wcfg [NT];
   int wcnt [NT];
   always @(posedge clk) begin
      for (int i = 0; i < NT; i++) begin
         wcnt[i] <= (apb_psel[i] && apb_penable[i]) ? wcnt[i] + 1 : 0;
      end
   end
   always_comb begin
      apb_pready = '0;
      for (int i = 0; i < NT; i++) begin
         apb_pready[i] = apb_psel[i] && apb_penable[i] && (wcnt[i] == wcfg[i]);
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      logic        rid;
      int          cyc;
   } exp_t;
   exp_t exq [$];

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Response monitor: pops the scoreboard on every rvalid&&rready.
   initial begin
      int   first;
      bit   seen;
      exp_t e;
      seen  = 1'b0;
      first = 0;
      forever begin
         @(negedge clk);
         if (!reset_n) begin
            seen = 1'b0;
         end else if (obi_rvalid) begin
            if (!seen) begin
               seen  = 1'b1;
               first = cyc;
               chk("psel_low_in_resp", 32'(apb_psel), 32'h0);
            end
            if (obi_rready) begin
               if (exq.size() == 0) begin
                  chk("unexpected_rvalid", 32'd1, 32'd0);
               end else begin
                  e = exq.pop_front();
                  chk("rdata", obi_rdata, e.rdata);
                  chk("err", 32'(obi_err), 32'(e.err));
                  chk("rid", 32'(obi_rid), 32'(e.rid));
                  chk("rvalid_latency", 32'(first), 32'(e.cyc));
               end
               seen = 1'b0;
            end
         end
      end
   end

   task automatic wait_gnt(output bit ok);
      ok = 1'b0;
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         if (obi_gnt) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) chk("gnt_timeout", 32'd0, 32'd1);
   endtask

   task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] be,
                         input logic [31:0] wd, input logic aid,
                         input logic [31:0] exp_rd, input logic exp_err,
                         input int lat, input int tgt, input bit keep);
      bit   ok;
      exp_t e;
      @(posedge clk);
      #1;
      obi_req   = 1'b1;
      obi_addr  = a;
      obi_we    = we;
      obi_be    = be;
      obi_wdata = wd;
      obi_aid   = aid;
      wait_gnt(ok);
      if (ok) begin
         e.rdata = exp_rd;
         e.err   = exp_err;
         e.rid   = aid;
         e.cyc   = cyc + lat;
         exq.push_back(e);
      end
      @(posedge clk);
      #1;
      if (!keep) obi_req = 1'b0;
      @(negedge clk);
      chk("setup_psel", 32'(apb_psel), (tgt >= 0) ? (32'd1 << tgt) : 32'd0);
      chk("setup_penable", 32'(apb_penable), 32'd0);
      if (tgt >= 0) begin
         chk("setup_paddr", apb_paddr[tgt*32 +: 32], a);
         chk("setup_pwrite", 32'(apb_pwrite[tgt]), 32'(we));
         chk("setup_pstrb", 32'(apb_pstrb[tgt*4 +: 4]), we ? 32'(be) : 32'd0);
         if (we) chk("setup_pwdata", apb_pwdata[tgt*32 +: 32], wd);
         @(negedge clk);
         chk("access_penable", 32'(apb_penable), 32'd1 << tgt);
      end
   endtask

   task automatic drain;
      for (int k = 0; k < 100; k++) begin
         if (exq.size() == 0) break;
         @(negedge clk);
      end
      if (exq.size() != 0) begin
         chk("drain_timeout", 32'(exq.size()), 32'd0);
         exq.delete();
      end
      @(negedge clk);
   endtask

   initial begin
      bit   ok;
      exp_t e;
      reset_n       = 1'b0;
      obi_req       = 1'b0;
      obi_addr      = '0;
      obi_we        = 1'b0;
      obi_be        = '0;
      obi_wdata     = '0;
      obi_aid       = '0;
      obi_reqpar    = 1'b0;
      obi_rready    = 1'b1;
      obi_rreadypar = 1'b1;
      ss_ctrl_icn   = 7'h1F;
      apb_pslverr   = '0;
      apb_prdata    = '0;
      apb_prdata[0*32 +: 32] = 32'hAAAA_0000;
      apb_prdata[1*32 +: 32] = 32'h0000_BEEF;
      apb_prdata[2*32 +: 32] = 32'hCAFE_0002;
      apb_prdata[3*32 +: 32] = 32'h3333_0003;
      apb_prdata[4*32 +: 32] = 32'hDEAD_0004;
      for (int i = 0; i < NT; i++) wcfg[i] = 0;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_gnt", 32'(obi_gnt), 32'd0);
      chk("rst_rvalid", 32'(obi_rvalid), 32'd0);
      chk("rst_err", 32'(obi_err), 32'd0);
      chk("rst_rdata", obi_rdata, 32'd0);
      chk("rst_rid", 32'(obi_rid), 32'd0);
      chk("rst_psel", 32'(apb_psel), 32'd0);
      chk("rst_penable", 32'(apb_penable), 32'd0);
      chk("rst_pwrite", 32'(apb_pwrite), 32'd0);
      chk("rst_paddr", 32'(|apb_paddr), 32'd0);
      chk("rst_pwdata", 32'(|apb_pwdata), 32'd0);
      chk("rst_pstrb", 32'(|apb_pstrb), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;

      // Zero-wait read on target 2.
      do_req(32'h0105_2004, 1'b0, 4'hF, 32'h0, 1'b1, 32'hCAFE_0002, 1'b0, 3, 2, 1'b0);
      drain();
      // Write on target 4: response data forced to zero.
      do_req(32'h0105_4000, 1'b1, 4'b0011, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 3, 4, 1'b0);
      drain();
      // Unmapped above, unmapped below, disabled target.
      do_req(32'h0105_5000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, 1, -1, 1'b0);
      drain();
      do_req(32'h0104_FFFC, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 1, -1, 1'b0);
      drain();
      ss_ctrl_icn = 7'h1D;
      do_req(32'h0105_1000, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0, 1'b1, 1, -1, 1'b0);
      drain();
      ss_ctrl_icn = 7'h1F;

      // Hung target 0: 8 ACCESS cycles (2..9), forced error at cycle 10.
      wcfg[0] = 1000;
      do_req(32'h0105_0000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h0, 1'b1, 10, 0, 1'b0);
      drain();
      wcfg[0] = 0;

      // Target 1: 3 wait states with PSLVERR, response at cycle 6.
      wcfg[1]        = 3;
      apb_pslverr[1] = 1'b1;
      do_req(32'h0105_1008, 1'b0, 4'hF, 32'h0, 1'b1, 32'h0000_BEEF, 1'b1, 6, 1, 1'b0);
      drain();
      wcfg[1]        = 0;
      apb_pslverr[1] = 1'b0;

      // Back-pressure: rready low while req stays high.
      wcfg[3]    = 1;
      obi_rready = 1'b0;
      do_req(32'h0105_3010, 1'b0, 4'hF, 32'h0, 1'b1, 32'h3333_0003, 1'b0, 4, 3, 1'b1);
      for (int k = 0; k < 20; k++) begin
         if (obi_rvalid) break;
         @(negedge clk);
      end
      for (int k = 0; k < 5; k++) begin
         chk("hold_rvalid", 32'(obi_rvalid), 32'd1);
         chk("hold_rdata", obi_rdata, 32'h3333_0003);
         chk("hold_no_gnt", 32'(obi_gnt), 32'd0);
         @(negedge clk);
      end
      @(posedge clk);
      #1 obi_rready = 1'b1;
      @(negedge clk);
      chk("hs_cycle_no_gnt", 32'(obi_gnt), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("gnt_after_hs", 32'(obi_gnt), 32'd1);
      if (obi_gnt) begin
         e.rdata = 32'h3333_0003;
         e.err   = 1'b0;
         e.rid   = 1'b1;
         e.cyc   = cyc + 4;
         exq.push_back(e);
      end
      @(posedge clk);
      #1 obi_req = 1'b0;
      drain();

      // Reset pulse in ACCESS on a hung target 3, then a clean transfer.
      wcfg[3] = 1000;
      @(posedge clk);
      #1;
      obi_req  = 1'b1;
      obi_addr = 32'h0105_3000;
      obi_we   = 1'b0;
      obi_aid  = 1'b0;
      wait_gnt(ok);
      @(posedge clk);
      #1 obi_req = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("pre_rst_penable", 32'(apb_penable), 32'h8);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_psel", 32'(apb_psel), 32'd0);
      chk("arst_penable", 32'(apb_penable), 32'd0);
      chk("arst_rvalid", 32'(obi_rvalid), 32'd0);
      chk("arst_paddr", 32'(|apb_paddr), 32'd0);
      chk("arst_gnt", 32'(obi_gnt), 32'd0);
      @(posedge clk);
      #1 reset_n = 1'b1;
      wcfg[3] = 0;
      do_req(32'h0105_3000, 1'b0, 4'hF, 32'h0, 1'b0, 32'h3333_0003, 1'b0, 3, 3, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: bench did not complete");
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
